// File: rtl/health_pkg.sv
// Shared types and default constants for the player health controller.
// Both the controller and its edge detectors import this package.
package health_pkg;

  localparam int HEALTH_W = 4;
  localparam int CNT_W    = 8;

  // Defaults for the health_controller parameters of the same base name.
  localparam int DEF_MAX_HEALTH    = 3;
  localparam int DEF_INVULN_FRAMES = 90;
  localparam int DEF_BLINK_FRAMES  = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ALIVE  = 2'd1,
    INVULN = 2'd2,
    DEAD   = 2'd3
  } health_state_t;

  function automatic logic [HEALTH_W-1:0] heal_sat(
    input logic [HEALTH_W-1:0] health,
    input logic [HEALTH_W-1:0] max_health
  );
    return (health >= max_health) ? max_health : health + 1'b1;
  endfunction

endpackage

// File: rtl/health_edge_det.sv
// Single-bit rising-edge detector. The delay flop clears on reset, so a level
// that is already high when reset is released counts as an edge.
module health_edge_det
  import health_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise
);

  logic level_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level_d <= 1'b0;
    end else begin
      level_d <= level;
    end
  end

  assign rise = level & ~level_d;

endmodule

// File: rtl/health_controller.sv
// Player health owner: hit/heal events, frame-timed invulnerability window
// with sprite blink, and game-over flag.
//
//   state  | meaning
//   IDLE   | no game running, health 0, waiting for game_start
//   ALIVE  | playing; hits decrement health, heals restore it
//   INVULN | post-hit grace window; hits discarded, heals still apply
//   DEAD   | health reached 0; waiting for game_start
module health_controller
  import health_pkg::*;
#(
  parameter int MAX_HEALTH    = DEF_MAX_HEALTH,
  parameter int INVULN_FRAMES = DEF_INVULN_FRAMES,
  parameter int BLINK_FRAMES  = DEF_BLINK_FRAMES
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                frame_tick,
  input  logic                game_start,
  input  logic                hit,
  input  logic                heal,
  output logic [HEALTH_W-1:0] present_health,
  output logic                invuln,
  output logic                blink_hide,
  output logic                game_over
);

  localparam logic [HEALTH_W-1:0] MAX_H      = HEALTH_W'(MAX_HEALTH);
  localparam logic [HEALTH_W-1:0] ONE_H      = HEALTH_W'(1);
  localparam logic [CNT_W-1:0]    INV_LAST   = CNT_W'(INVULN_FRAMES - 1);
  localparam logic [CNT_W-1:0]    BLINK_LOAD = CNT_W'(BLINK_FRAMES - 1);

  health_state_t       state;
  logic [HEALTH_W-1:0] health;
  logic [CNT_W-1:0]    inv_cnt;
  logic [CNT_W-1:0]    blink_cnt;
  logic                blink_ph;
  logic                hit_ev;
  logic                heal_ev;

  health_edge_det u_hit_edge (
    .clk   (clk),
    .rst   (rst),
    .level (hit),
    .rise  (hit_ev)
  );

  health_edge_det u_heal_edge (
    .clk   (clk),
    .rst   (rst),
    .level (heal),
    .rise  (heal_ev)
  );

  // blink_cnt is a down-counter reloaded on every half-period boundary, which
  // tracks (inv_cnt+1) mod BLINK_FRAMES == 0 without a divider.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      health    <= '0;
      inv_cnt   <= '0;
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (game_start) begin
            state  <= ALIVE;
            health <= MAX_H;
          end
        end

        ALIVE: begin
          if (hit_ev) begin
            if (health > ONE_H) begin
              health    <= health - 1'b1;
              state     <= INVULN;
              inv_cnt   <= '0;
              blink_cnt <= BLINK_LOAD;
              blink_ph  <= 1'b0;
            end else begin
              health <= '0;
              state  <= DEAD;
            end
          end else if (heal_ev) begin
            health <= heal_sat(health, MAX_H);
          end
        end

        INVULN: begin
          if (heal_ev) begin
            health <= heal_sat(health, MAX_H);
          end
          if (frame_tick) begin
            inv_cnt <= inv_cnt + 1'b1;
            if (blink_cnt == '0) begin
              blink_ph  <= ~blink_ph;
              blink_cnt <= BLINK_LOAD;
            end else begin
              blink_cnt <= blink_cnt - 1'b1;
            end
            if (inv_cnt == INV_LAST) begin
              state <= ALIVE;
            end
          end
        end

        DEAD: begin
          if (game_start) begin
            state  <= ALIVE;
            health <= MAX_H;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign present_health = health;
  assign invuln         = (state == INVULN);
  assign blink_hide     = invuln & blink_ph;
  assign game_over      = (state == DEAD);

endmodule

// File: tb/tb_health_controller.sv
// Bench for health_controller: directed scenarios plus a randomized run, all
// checked against a frame-counting behavioural model of the health rules.
module tb_health_controller;
  import health_pkg::*;

  localparam int MAXH = 3;
  localparam int INVF = 90;
  localparam int BLK  = 8;

  localparam int M_IDLE  = 0;
  localparam int M_ALIVE = 1;
  localparam int M_INV   = 2;
  localparam int M_DEAD  = 3;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                frame_tick = 1'b0;
  logic                game_start = 1'b0;
  logic                hit = 1'b0;
  logic                heal = 1'b0;
  logic [HEALTH_W-1:0] present_health;
  logic                invuln;
  logic                blink_hide;
  logic                game_over;

  int checks = 0;
  int failures = 0;

  int m_health;
  int m_mode;
  int m_ticks;
  bit m_prev_hit;
  bit m_prev_heal;

  health_controller #(
    .MAX_HEALTH    (MAXH),
    .INVULN_FRAMES (INVF),
    .BLINK_FRAMES  (BLK)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .frame_tick     (frame_tick),
    .game_start     (game_start),
    .hit            (hit),
    .heal           (heal),
    .present_health (present_health),
    .invuln         (invuln),
    .blink_hide     (blink_hide),
    .game_over      (game_over)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [HEALTH_W-1:0] exp_health();
    return HEALTH_W'(m_health);
  endfunction

  function automatic logic exp_invuln();
    return m_mode == M_INV;
  endfunction

  // Sprite is hidden during odd-numbered blink half-periods of the window.
  function automatic logic exp_blink();
    return (m_mode == M_INV) && (((m_ticks / BLK) % 2) == 1);
  endfunction

  function automatic logic exp_over();
    return m_mode == M_DEAD;
  endfunction

  task automatic model_reset();
    m_health    = 0;
    m_mode      = M_IDLE;
    m_ticks     = 0;
    m_prev_hit  = 1'b0;
    m_prev_heal = 1'b0;
  endtask

  task automatic model_update(input bit h, input bit l, input bit t, input bit s);
    bit hev;
    bit lev;
    hev = h && !m_prev_hit;
    lev = l && !m_prev_heal;
    m_prev_hit  = h;
    m_prev_heal = l;
    case (m_mode)
      M_IDLE, M_DEAD: begin
        if (s) begin
          m_mode   = M_ALIVE;
          m_health = MAXH;
        end
      end
      M_ALIVE: begin
        if (hev) begin
          if (m_health > 1) begin
            m_health = m_health - 1;
            m_mode   = M_INV;
            m_ticks  = 0;
          end else begin
            m_health = 0;
            m_mode   = M_DEAD;
          end
        end else if (lev && m_health < MAXH) begin
          m_health = m_health + 1;
        end
      end
      default: begin
        if (lev && m_health < MAXH) m_health = m_health + 1;
        if (t) begin
          m_ticks = m_ticks + 1;
          if (m_ticks == INVF) m_mode = M_ALIVE;
        end
      end
    endcase
  endtask

  // Drive one cycle of inputs at the falling edge, sample 1 ns after the rising edge.
  task automatic step(input bit h, input bit l, input bit t, input bit s);
    @(negedge clk);
    hit        = h;
    heal       = l;
    frame_tick = t;
    game_start = s;
    model_update(h, l, t, s);
    @(posedge clk);
    #1;
  endtask

  task automatic run_window();
    for (int i = 0; i < INVF; i++) begin
      step(0, 0, 1, 0);
      step(0, 0, 0, 0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    model_reset();
    #12;
    checks++; if (present_health !== 4'd0) begin failures++; $display("FAIL reset_health got %0d want 0", present_health); end
    checks++; if (invuln !== 1'b0) begin failures++; $display("FAIL reset_invuln got %b want 0", invuln); end
    checks++; if (blink_hide !== 1'b0) begin failures++; $display("FAIL reset_blink got %b want 0", blink_hide); end
    checks++; if (game_over !== 1'b0) begin failures++; $display("FAIL reset_over got %b want 0", game_over); end
    @(negedge clk);
    rst = 1'b1;
    step(0, 0, 1, 0);
    step(0, 1, 0, 0);
    checks++; if (present_health !== exp_health()) begin failures++; $display("FAIL idle_health got %0d want %0d", present_health, exp_health()); end
    step(0, 0, 0, 0);
  endtask

  task automatic test_start();
    step(0, 0, 0, 1);
    checks++; if (present_health !== 4'd3) begin failures++; $display("FAIL start_health got %0d want 3", present_health); end
    checks++; if (invuln !== 1'b0 || game_over !== 1'b0) begin failures++; $display("FAIL start_flags got inv=%b over=%b want 0 0", invuln, game_over); end
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    checks++; if (present_health !== exp_health()) begin failures++; $display("FAIL start_in_alive got %0d want %0d", present_health, exp_health()); end
    step(0, 0, 0, 0);
  endtask

  task automatic test_invuln_window();
    logic want_blink;
    step(1, 0, 0, 0);
    checks++; if (present_health !== 4'd2) begin failures++; $display("FAIL hit_health got %0d want 2", present_health); end
    checks++; if (invuln !== 1'b1) begin failures++; $display("FAIL hit_invuln got %b want 1", invuln); end
    step(0, 0, 0, 0);
    for (int i = 1; i < INVF; i++) begin
      step(0, 0, 1, 0);
      want_blink = ((i / BLK) % 2) == 1;
      checks++; if (invuln !== 1'b1) begin failures++; $display("FAIL window_invuln tick %0d got %b want 1", i, invuln); end
      checks++; if (blink_hide !== want_blink) begin failures++; $display("FAIL window_blink tick %0d got %b want %b", i, blink_hide, want_blink); end
      step(0, 0, 0, 0);
    end
    step(0, 0, 1, 0);
    checks++; if (invuln !== 1'b0) begin failures++; $display("FAIL window_end_invuln got %b want 0", invuln); end
    checks++; if (blink_hide !== 1'b0) begin failures++; $display("FAIL window_end_blink got %b want 0", blink_hide); end
    checks++; if (present_health !== exp_health()) begin failures++; $display("FAIL window_end_health got %0d want %0d", present_health, exp_health()); end
    step(0, 0, 0, 0);
  endtask

  task automatic test_hit_during_invuln();
    step(1, 0, 0, 0);
    checks++; if (present_health !== 4'd1) begin failures++; $display("FAIL second_hit got %0d want 1", present_health); end
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0, 0);
      step(1, 0, 1, 0);
      checks++; if (present_health !== exp_health() || invuln !== 1'b1) begin failures++; $display("FAIL invuln_hit_ignored got h=%0d inv=%b want h=%0d inv=1", present_health, invuln, exp_health()); end
    end
    while (m_mode == M_INV) step(1, 0, 1, 0);
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 0, 0);
      checks++; if (present_health !== 4'd1 || invuln !== 1'b0) begin failures++; $display("FAIL held_hit got h=%0d inv=%b want h=1 inv=0", present_health, invuln); end
    end
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    checks++; if (present_health !== 4'd0 || game_over !== 1'b1) begin failures++; $display("FAIL rehit_fatal got h=%0d over=%b want h=0 over=1", present_health, game_over); end
    step(0, 0, 0, 0);
  endtask

  task automatic test_death_sequence();
    logic [HEALTH_W-1:0] want;
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    for (int n = 1; n <= 3; n++) begin
      want = HEALTH_W'(3 - n);
      step(1, 0, 0, 0);
      checks++; if (present_health !== want) begin failures++; $display("FAIL death_seq hit %0d got %0d want %0d", n, present_health, want); end
      step(0, 0, 0, 0);
      if (n < 3) run_window();
    end
    checks++; if (game_over !== 1'b1 || invuln !== 1'b0) begin failures++; $display("FAIL death_flags got over=%b inv=%b want 1 0", game_over, invuln); end
    step(0, 1, 0, 0);
    step(1, 0, 1, 0);
    checks++; if (present_health !== 4'd0 || game_over !== 1'b1) begin failures++; $display("FAIL dead_heal got h=%0d over=%b want h=0 over=1", present_health, game_over); end
    step(0, 0, 0, 0);
  endtask

  task automatic test_heal_and_simultaneous();
    step(0, 0, 0, 1);
    step(0, 1, 0, 0);
    checks++; if (present_health !== 4'd3) begin failures++; $display("FAIL heal_saturate got %0d want 3", present_health); end
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 1, 0);
    checks++; if (present_health !== 4'd3 || invuln !== 1'b1) begin failures++; $display("FAIL invuln_heal got h=%0d inv=%b want h=3 inv=1", present_health, invuln); end
    step(0, 0, 0, 0);
    while (m_mode == M_INV) step(0, 0, 1, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    while (m_mode == M_INV) step(0, 0, 1, 0);
    checks++; if (present_health !== 4'd2 || invuln !== 1'b0) begin failures++; $display("FAIL simul_setup got h=%0d inv=%b want h=2 inv=0", present_health, invuln); end
    step(1, 1, 0, 0);
    checks++; if (present_health !== 4'd1 || invuln !== 1'b1) begin failures++; $display("FAIL simul_alive got h=%0d inv=%b want h=1 inv=1", present_health, invuln); end
    step(0, 0, 0, 0);
    step(1, 1, 0, 0);
    checks++; if (present_health !== 4'd2 || invuln !== 1'b1) begin failures++; $display("FAIL simul_invuln got h=%0d inv=%b want h=2 inv=1", present_health, invuln); end
    step(0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 1, 0);
  endtask

  task automatic test_reset_mid();
    #2;
    rst = 1'b0;
    #1;
    checks++; if (present_health !== 4'd0 || invuln !== 1'b0 || blink_hide !== 1'b0 || game_over !== 1'b0) begin
      failures++; $display("FAIL async_reset got h=%0d inv=%b blink=%b over=%b want all 0", present_health, invuln, blink_hide, game_over);
    end
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    step(0, 0, 0, 1);
    checks++; if (present_health !== 4'd3 || invuln !== 1'b0) begin failures++; $display("FAIL reset_release_start got h=%0d inv=%b want h=3 inv=0", present_health, invuln); end
    step(0, 0, 0, 0);
  endtask

  task automatic test_random();
    bit h = 1'b0;
    bit l = 1'b0;
    bit t;
    bit s;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) h = ~h;
      if ($urandom_range(0, 11) == 0) l = ~l;
      t = ($urandom_range(0, 2) == 0);
      s = ($urandom_range(0, 79) == 0);
      step(h, l, t, s);
      checks++; if (present_health !== exp_health()) begin failures++; $display("FAIL rand_health cyc %0d got %0d want %0d", i, present_health, exp_health()); end
      checks++; if (invuln !== exp_invuln()) begin failures++; $display("FAIL rand_invuln cyc %0d got %b want %b", i, invuln, exp_invuln()); end
      checks++; if (blink_hide !== exp_blink()) begin failures++; $display("FAIL rand_blink cyc %0d got %b want %b", i, blink_hide, exp_blink()); end
      checks++; if (game_over !== exp_over()) begin failures++; $display("FAIL rand_over cyc %0d got %b want %b", i, game_over, exp_over()); end
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_invuln_window();
    test_hit_during_invuln();
    test_death_sequence();
    test_heal_and_simultaneous();
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
